imem_ctrl_46: RTL and testbench

Instruction-memory controller in front of ins_mem_46, sequencing the shared memory between two users. The first is the IF stage, which fetches instructions by PC. The second is a program loader that streams words into the memory over a valid/ready handshake. The block owns the PC, the fetch pipeline register and the memory write port, and stalls fetch while a load is in progress.

---
 rtl/imem_ctrl_46_pkg.sv | 20 ++
 rtl/imem_ctrl_46_if.sv | 39 +++
 rtl/imem_ctrl_46_loader.sv | 112 +++++++++++
 rtl/imem_ctrl_46.sv | 79 +++++++
 tb/tb_imem_ctrl_46.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_ctrl_46_pkg.sv
// Shared state encoding, geometry constants and helpers for the imem_ctrl_46 controller.
package imem_pkg_46;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } imem_state_e;

   localparam int          IMEM_STEP     = 4;
   localparam int          IMEM_MAX_ADDR = 2000;
   localparam int          IMEM_CW       = 16;
   localparam logic [31:0] IMEM_NOP      = 32'h0000_003F;

   // A word is writable only when its last byte still lies at or below max_addr.
   function automatic logic word_fits(input logic [31:0] addr, input int step, input int max_addr);
      return ({1'b0, addr} + 33'(step - 1)) <= 33'(max_addr);
   endfunction

endpackage

// File: rtl/imem_ctrl_46_if.sv
// Bus bundle between the environment (fetch/hazard/loader/ins_mem) and imem_ctrl_46.
interface imem_ctrl_46_if #(
   parameter int CW = imem_pkg_46::IMEM_CW
);
   logic          load_start_46;
   logic [31:0]   load_base_46;
   logic [CW-1:0] load_count_46;
   logic          ld_valid_46;
   logic [31:0]   ld_data_46;
   logic          ld_ready_46;
   logic [31:0]   mem_waddr_46;
   logic [31:0]   mem_wdata_46;
   logic          mem_write_46;
   logic [31:0]   mem_raddr_46;
   logic [31:0]   mem_rdata_46;
   logic          stall_46;
   logic          redirect_46;
   logic [31:0]   redirect_pc_46;
   logic [31:0]   pc_46;
   logic [31:0]   instr_46;
   logic          instr_valid_46;
   logic          busy_46;
   logic          load_done_46;
   logic          load_err_46;

   modport master (
      output load_start_46, load_base_46, load_count_46, ld_valid_46, ld_data_46,
             mem_rdata_46, stall_46, redirect_46, redirect_pc_46,
      input  ld_ready_46, mem_waddr_46, mem_wdata_46, mem_write_46, mem_raddr_46,
             pc_46, instr_46, instr_valid_46, busy_46, load_done_46, load_err_46
   );

   modport slave (
      input  load_start_46, load_base_46, load_count_46, ld_valid_46, ld_data_46,
             mem_rdata_46, stall_46, redirect_46, redirect_pc_46,
      output ld_ready_46, mem_waddr_46, mem_wdata_46, mem_write_46, mem_raddr_46,
             pc_46, instr_46, instr_valid_46, busy_46, load_done_46, load_err_46
   );
endinterface

// File: rtl/imem_ctrl_46_loader.sv
// Loader sequencer: RUN/LOAD/DRAIN FSM, word counter, write-address generator, sticky range error.
// One word per cycle in LOAD (ready is a registered state decode); exactly one DRAIN cycle before RUN.
module imem_loader_46
   import imem_pkg_46::*;
#(
   parameter int STEP     = IMEM_STEP,
   parameter int MAX_ADDR = IMEM_MAX_ADDR,
   parameter int CW       = IMEM_CW
) (
   input  logic          clk_46,
   input  logic          rst_46,
   input  logic          i_start,
   input  logic [31:0]   i_base,
   input  logic [CW-1:0] i_count,
   input  logic          i_ld_vld,
   input  logic [31:0]   i_ld_dat,
   output logic          o_ld_rdy,
   output logic [31:0]   o_mem_waddr,
   output logic [31:0]   o_mem_wdata,
   output logic          o_mem_write,
   output logic          o_run,
   output logic          o_accept,
   output logic          o_drain,
   output logic [31:0]   o_base,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);
   imem_state_e   r_state;
   logic [31:0]   r_base;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_idx;
   logic          r_ld_rdy;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic [31:0]   w_addr;
   logic          w_fits;
   logic          w_xfer;
   logic          w_last;
   logic          w_run;

   assign w_addr = r_base + 32'(r_idx) * 32'(STEP);
   assign w_fits = word_fits(w_addr, STEP, MAX_ADDR);
   assign w_xfer = r_ld_rdy && i_ld_vld;
   assign w_last = (r_idx == r_count - CW'(1));
   assign w_run  = (r_state == ST_RUN);

   always_ff @(posedge clk_46) begin
      if (rst_46) begin
         r_state  <= ST_RUN;
         r_base   <= '0;
         r_count  <= '0;
         r_idx    <= '0;
         r_ld_rdy <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (i_start) begin
                  r_base  <= i_base;
                  r_count <= i_count;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  if (i_count == '0) begin
                     r_state <= ST_DRAIN;
                  end else begin
                     r_state  <= ST_LOAD;
                     r_ld_rdy <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (w_xfer) begin
                  r_idx <= r_idx + CW'(1);
                  if (!w_fits) r_err <= 1'b1;
                  if (w_last) begin
                     r_state  <= ST_DRAIN;
                     r_ld_rdy <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               r_state <= ST_RUN;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state  <= ST_RUN;
               r_ld_rdy <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   // Out-of-range words are still consumed so the loader stream never stalls.
   assign o_mem_write = w_xfer && w_fits;
   assign o_mem_waddr = o_mem_write ? w_addr   : '0;
   assign o_mem_wdata = o_mem_write ? i_ld_dat : '0;
   assign o_ld_rdy    = r_ld_rdy;
   assign o_run       = w_run;
   assign o_accept    = w_run && i_start;
   assign o_drain     = (r_state == ST_DRAIN);
   assign o_base      = r_base;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
endmodule

// File: rtl/imem_ctrl_46.sv
// Instruction-memory controller: owns fetch PC and IF register, shares ins_mem_46 with the loader.
// PC-to-instr latency 1 cycle; stall holds, redirect inserts one bubble; fetch frozen while busy_46.
module imem_ctrl_46
   import imem_pkg_46::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          STEP     = IMEM_STEP,
   parameter int          MAX_ADDR = IMEM_MAX_ADDR,
   parameter int          CW       = IMEM_CW
) (
   input logic           clk_46,
   input logic           rst_46,
   imem_ctrl_46_if.slave bus
);
   logic [31:0] r_fpc;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_valid;
   logic        w_run;
   logic        w_accept;
   logic        w_drain;
   logic [31:0] w_base;

   imem_loader_46 #(
      .STEP     (STEP),
      .MAX_ADDR (MAX_ADDR),
      .CW       (CW)
   ) u_loader (
      .clk_46      (clk_46),
      .rst_46      (rst_46),
      .i_start     (bus.load_start_46),
      .i_base      (bus.load_base_46),
      .i_count     (bus.load_count_46),
      .i_ld_vld    (bus.ld_valid_46),
      .i_ld_dat    (bus.ld_data_46),
      .o_ld_rdy    (bus.ld_ready_46),
      .o_mem_waddr (bus.mem_waddr_46),
      .o_mem_wdata (bus.mem_wdata_46),
      .o_mem_write (bus.mem_write_46),
      .o_run       (w_run),
      .o_accept    (w_accept),
      .o_drain     (w_drain),
      .o_base      (w_base),
      .o_busy      (bus.busy_46),
      .o_done      (bus.load_done_46),
      .o_err       (bus.load_err_46)
   );

   // Priority: load start > redirect > stall > normal fetch.
   always_ff @(posedge clk_46) begin
      if (rst_46) begin
         r_fpc   <= RESET_PC;
         r_pc    <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b0;
         r_instr <= IMEM_NOP;
      end else if (w_drain) begin
         r_fpc <= w_base;
      end else if (w_run) begin
         if (bus.redirect_46) begin
            r_fpc   <= bus.redirect_pc_46;
            r_valid <= 1'b0;
            r_instr <= IMEM_NOP;
         end else if (!bus.stall_46) begin
            r_instr <= bus.mem_rdata_46;
            r_pc    <= r_fpc;
            r_valid <= 1'b1;
            r_fpc   <= r_fpc + 32'(STEP);
         end
      end
   end

   assign bus.mem_raddr_46   = r_fpc;
   assign bus.pc_46          = r_pc;
   assign bus.instr_46       = r_instr;
   assign bus.instr_valid_46 = r_valid;
endmodule

// File: tb/tb_imem_ctrl_46.sv
// Self-checking bench for imem_ctrl_46: fetch vector table, hand load/abort sequences, randomized mix.
module tb_imem_ctrl_46;
   import imem_pkg_46::*;

   logic clk_46 = 1'b0;
   logic rst_46;
   always #5 clk_46 = ~clk_46;

   imem_ctrl_46_if bus ();
   imem_ctrl_46 dut (.clk_46(clk_46), .rst_46(rst_46), .bus(bus));

   logic [31:0] mem     [0:511];
   logic [31:0] ref_mem [0:511];
   logic        mem_init;
   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference model of the fetch side and the sticky error.
   logic [31:0] m_fetch;
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_err;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] tgt;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t vecs [13];

   function automatic logic [31:0] seed_word(input int i);
      return 32'h1357_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // Whole 4-byte word must sit at or below byte index 2000.
   function automatic bit legal(input logic [31:0] a);
      return (33'(a) + 33'd3) <= 33'd2000;
   endfunction

   always @(posedge clk_46) begin
      if (mem_init) begin
         for (int i = 0; i < 512; i++) mem[i] <= seed_word(i);
      end else if (bus.mem_write_46) begin
         mem[bus.mem_waddr_46[10:2]] <= bus.mem_wdata_46;
      end
   end
   assign bus.mem_rdata_46 = mem[bus.mem_raddr_46[10:2]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_cycle(input logic s, input logic d, input logic [31:0] t);
      @(negedge clk_46);
      bus.load_start_46  = 1'b0;
      bus.stall_46       = s;
      bus.redirect_46    = d;
      bus.redirect_pc_46 = t;
      bus.ld_valid_46    = 1'($urandom_range(0, 1));
      bus.ld_data_46     = $urandom;
      #1;
      check("run_raddr", bus.mem_raddr_46, m_fetch);
      check1("run_mem_write", bus.mem_write_46, 1'b0);
      check1("run_ld_ready", bus.ld_ready_46, 1'b0);
      @(posedge clk_46);
      #1;
      if (d) begin
         m_valid = 1'b0;
         m_fetch = t;
      end else if (!s) begin
         m_pc    = m_fetch;
         m_valid = 1'b1;
         m_fetch = m_fetch + 32'd4;
      end
      check1("run_valid", bus.instr_valid_46, m_valid);
      if (m_valid) begin
         check("run_pc", bus.pc_46, m_pc);
         check("run_instr", bus.instr_46, ref_mem[m_pc[10:2]]);
      end
      check1("run_busy", bus.busy_46, 1'b0);
      check1("run_done", bus.load_done_46, 1'b0);
   endtask

   // Full load transaction; returns right after word abort_at is accepted when abort_at >= 0.
   task automatic do_load(input logic [31:0] base, input int cnt, input int vld_pct, input int abort_at);
      int          acc = 0;
      int          cyc = 0;
      logic        exp_w;
      logic [31:0] a;
      @(negedge clk_46);
      bus.load_start_46  = 1'b1;
      bus.load_base_46   = base;
      bus.load_count_46  = 16'(cnt);
      bus.stall_46       = 1'($urandom_range(0, 1));
      bus.redirect_46    = 1'($urandom_range(0, 1));
      bus.redirect_pc_46 = 32'h0000_0044;
      bus.ld_valid_46    = 1'b0;
      @(posedge clk_46);
      #1;
      check1("ld_start_valid", bus.instr_valid_46, 1'b0);
      check1("ld_start_busy", bus.busy_46, 1'b1);
      m_valid = 1'b0;
      while (acc < cnt && cyc < 200) begin
         @(negedge clk_46);
         bus.load_start_46  = 1'($urandom_range(0, 1));
         bus.load_base_46   = $urandom;
         bus.load_count_46  = 16'($urandom_range(0, 9));
         bus.stall_46       = 1'($urandom_range(0, 1));
         bus.redirect_46    = 1'($urandom_range(0, 1));
         bus.redirect_pc_46 = $urandom;
         bus.ld_valid_46    = ($urandom_range(0, 99) < vld_pct);
         bus.ld_data_46     = $urandom;
         a     = base + 32'(acc) * 32'd4;
         exp_w = bus.ld_valid_46 && legal(a);
         #1;
         check1("ld_ready", bus.ld_ready_46, 1'b1);
         check1("ld_mem_write", bus.mem_write_46, exp_w);
         check("ld_waddr", bus.mem_waddr_46, exp_w ? a : 32'h0);
         check("ld_wdata", bus.mem_wdata_46, exp_w ? bus.ld_data_46 : 32'h0);
         if (bus.ld_valid_46) begin
            if (legal(a)) ref_mem[a[10:2]] = bus.ld_data_46;
            else          m_err = 1'b1;
            acc++;
         end
         @(posedge clk_46);
         #1;
         check1("ld_instr_valid", bus.instr_valid_46, 1'b0);
         check1("ld_busy", bus.busy_46, 1'b1);
         cyc++;
         if (acc == abort_at) return;
      end
      check("ld_word_count", 32'(acc), 32'(cnt));
      // DRAIN: loader inputs and a fresh start request must both be ignored.
      @(negedge clk_46);
      bus.load_start_46 = 1'b1;
      bus.load_base_46  = 32'h0000_0600;
      bus.load_count_46 = 16'd3;
      bus.ld_valid_46   = 1'b1;
      bus.ld_data_46    = $urandom;
      #1;
      check1("drain_ready", bus.ld_ready_46, 1'b0);
      check1("drain_write", bus.mem_write_46, 1'b0);
      check("drain_waddr", bus.mem_waddr_46, 32'h0);
      check("drain_wdata", bus.mem_wdata_46, 32'h0);
      check1("drain_busy", bus.busy_46, 1'b1);
      @(posedge clk_46);
      #1;
      check1("done_pulse", bus.load_done_46, 1'b1);
      check1("done_busy", bus.busy_46, 1'b0);
      check1("done_valid", bus.instr_valid_46, 1'b0);
      check1("done_err", bus.load_err_46, m_err);
      check("done_fetch_pc", bus.mem_raddr_46, base);
      m_fetch = base;
      m_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC};
      vecs[7]  = '{1'b1, 1'b1, 32'h30, 1'b0, 32'hC};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h30};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h34};
      vecs[10] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h34};
      vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h34};
      vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h40};
      for (int i = 0; i < 512; i++) ref_mem[i] = seed_word(i);

      rst_46             = 1'b1;
      mem_init           = 1'b1;
      bus.load_start_46  = 1'b0;
      bus.load_base_46   = '0;
      bus.load_count_46  = '0;
      bus.ld_valid_46    = 1'b0;
      bus.ld_data_46     = '0;
      bus.stall_46       = 1'b0;
      bus.redirect_46    = 1'b0;
      bus.redirect_pc_46 = '0;
      m_fetch = 32'h0;
      m_pc    = 32'h0;
      m_valid = 1'b0;
      m_err   = 1'b0;

      repeat (2) @(posedge clk_46);
      #1;
      check("rst_pc", bus.pc_46, 32'h0);
      check("rst_instr", bus.instr_46, 32'h0);
      check1("rst_valid", bus.instr_valid_46, 1'b0);
      check1("rst_ld_ready", bus.ld_ready_46, 1'b0);
      check1("rst_mem_write", bus.mem_write_46, 1'b0);
      check1("rst_busy", bus.busy_46, 1'b0);
      check1("rst_done", bus.load_done_46, 1'b0);
      check1("rst_err", bus.load_err_46, 1'b0);
      check("rst_fetch_pc", bus.mem_raddr_46, 32'h0);
      rst_46   = 1'b0;
      mem_init = 1'b0;

      for (int k = 0; k < 13; k++) begin
         run_cycle(vecs[k].stall, vecs[k].redir, vecs[k].tgt);
         check1($sformatf("tbl%0d_valid", k), bus.instr_valid_46, vecs[k].exp_valid);
         if (vecs[k].exp_valid) check($sformatf("tbl%0d_pc", k), bus.pc_46, vecs[k].exp_pc);
      end

      do_load(32'h0000_0100, 3, 50, -1);
      run_cycle(1'b0, 1'b0, 32'h0);
      check("load_first_pc", bus.pc_46, 32'h100);
      check("load_first_instr", bus.instr_46, mem[32'h100 >> 2]);
      run_cycle(1'b0, 1'b0, 32'h0);

      do_load(32'h0000_07CC, 3, 70, -1);
      check1("err_set", bus.load_err_46, 1'b1);
      check("err_word0", mem[499], ref_mem[499]);
      check("err_word1_kept", mem[500], seed_word(500));
      check("err_word2_kept", mem[501], seed_word(501));
      do_load(32'h0000_0010, 0, 50, -1);
      check1("err_sticky", bus.load_err_46, 1'b1);
      repeat (3) run_cycle(1'b0, 1'b0, 32'h0);

      do_load(32'h0000_0200, 5, 100, 2);
      @(negedge clk_46);
      rst_46            = 1'b1;
      bus.ld_valid_46   = 1'b0;
      bus.load_start_46 = 1'b0;
      @(posedge clk_46);
      #1;
      rst_46 = 1'b0;
      check1("abort_ld_ready", bus.ld_ready_46, 1'b0);
      check1("abort_busy", bus.busy_46, 1'b0);
      check1("abort_valid", bus.instr_valid_46, 1'b0);
      check1("abort_err", bus.load_err_46, 1'b0);
      check("abort_fetch_pc", bus.mem_raddr_46, 32'h0);
      check("abort_kept0", mem[32'h200 >> 2], ref_mem[32'h200 >> 2]);
      check("abort_kept1", mem[32'h204 >> 2], ref_mem[32'h204 >> 2]);
      check("abort_unwritten", mem[32'h208 >> 2], seed_word(32'h208 >> 2));
      m_fetch = 32'h0;
      m_valid = 1'b0;
      m_err   = 1'b0;

      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 19) == 0)
            do_load($urandom_range(0, 511) << 2, $urandom_range(0, 5), $urandom_range(40, 100), -1);
         else
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 511) << 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
